sram_bist: RTL

SRAM_BIST -- requirements
Module: sram_bist

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram16x128.sv | 35 +++
 rtl/sram_bist.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the 16x128 SRAM and its built-in self-test.
//   DW    : SRAM data width
//   AW    : SRAM address width
//   DEPTH : number of SRAM words
//   state_t : BIST sequencer states
package sram_pkg;

   localparam int unsigned DW    = 16;
   localparam int unsigned AW    = 7;
   localparam int unsigned DEPTH = 2 ** AW;

   typedef enum logic [2:0] {
      IDLE,
      WR0,
      RD0,
      CHK0,
      WR1,
      RD1,
      CHK1,
      DONE
   } state_t;

endpackage

// File: rtl/sram16x128.sv
// Single-port synchronous SRAM, 16 bits x 128 words.
// Ports:
//   clk  : clock
//   rst  : async active-low reset (clears the read register only)
//   we   : write enable, din stored at addr on posedge
//   re   : read enable, word at addr appears on dout after the posedge
//   addr : word address
//   din  : write data
//   dout : registered read data
module sram16x128
   import sram_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   logic [DW-1:0] mem [DEPTH];

   // storage array, no reset
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= din;
   end

   // read data register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    dout <= '0;
      else if (re) dout <= mem[addr];
   end

endmodule

// File: rtl/sram_bist.sv
// March-style BIST for a single-port SRAM: write PATTERN everywhere, read back
// and compare, then repeat with ~PATTERN. Stops at the first mismatch.
// Ports:
//   clk, rst   : clock, async active-low reset
//   start      : one-cycle request, honoured only in IDLE
//   mem_we/re  : SRAM write/read enables (never both high)
//   mem_addr   : SRAM address
//   mem_din    : SRAM write data
//   mem_dout   : SRAM read data, valid the cycle after a read is issued
//   busy       : test in progress
//   done       : one-cycle end-of-test pulse
//   fail       : sticky mismatch flag, cleared by the next accepted start
//   fail_addr  : address of the first mismatch
//   fail_data  : data read at fail_addr
module sram_bist
   import sram_pkg::*;
#(
   parameter int unsigned    DW      = sram_pkg::DW,
   parameter int unsigned    AW      = sram_pkg::AW,
   parameter logic [DW-1:0]  PATTERN = DW'(16'hA5C3)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          mem_we,
   output logic          mem_re,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout,
   output logic          busy,
   output logic          done,
   output logic          fail,
   output logic [AW-1:0] fail_addr,
   output logic [DW-1:0] fail_data
);

   localparam logic [AW-1:0] LAST = '1;

   state_t        state_q, state_d;
   logic          we_d, re_d, busy_d, done_d, fail_d;
   logic [AW-1:0] addr_d, fail_addr_d;
   logic [DW-1:0] din_d, fail_data_d;
   logic [DW-1:0] exp_c;
   logic          rd_vld_q, mismatch_c;
   logic [AW-1:0] rd_addr_q;
   logic [AW-1:0] addr_inc_c;

   assign addr_inc_c = mem_addr + AW'(1);

   // compare the word returned for last cycle's read against the pass pattern
   always_comb begin
      exp_c      = (state_q inside {RD1, CHK1}) ? ~PATTERN : PATTERN;
      mismatch_c = rd_vld_q && (state_q inside {RD0, CHK0, RD1, CHK1})
                   && (mem_dout != exp_c);
   end

   // next-state and registered-output decode
   always_comb begin
      state_d     = state_q;
      we_d        = 1'b0;
      re_d        = 1'b0;
      addr_d      = '0;
      din_d       = '0;
      fail_d      = fail;
      fail_addr_d = fail_addr;
      fail_data_d = fail_data;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = WR0;
               we_d        = 1'b1;
               din_d       = PATTERN;
               fail_d      = 1'b0;
               fail_addr_d = '0;
               fail_data_d = '0;
            end
         end
         WR0: begin
            if (mem_addr == LAST) begin
               state_d = RD0;
               re_d    = 1'b1;
            end else begin
               we_d   = 1'b1;
               din_d  = PATTERN;
               addr_d = addr_inc_c;
            end
         end
         RD0: begin
            if (mem_addr == LAST) begin
               state_d = CHK0;
            end else begin
               re_d   = 1'b1;
               addr_d = addr_inc_c;
            end
         end
         CHK0: begin
            state_d = WR1;
            we_d    = 1'b1;
            din_d   = ~PATTERN;
         end
         WR1: begin
            if (mem_addr == LAST) begin
               state_d = RD1;
               re_d    = 1'b1;
            end else begin
               we_d   = 1'b1;
               din_d  = ~PATTERN;
               addr_d = addr_inc_c;
            end
         end
         RD1: begin
            if (mem_addr == LAST) begin
               state_d = CHK1;
            end else begin
               re_d   = 1'b1;
               addr_d = addr_inc_c;
            end
         end
         CHK1:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // first mismatch aborts the test and silences the SRAM next cycle
      if (mismatch_c) begin
         state_d     = DONE;
         we_d        = 1'b0;
         re_d        = 1'b0;
         addr_d      = '0;
         din_d       = '0;
         fail_d      = 1'b1;
         fail_addr_d = rd_addr_q;
         fail_data_d = mem_dout;
      end

      done_d = (state_d == DONE);
      busy_d = !(state_d inside {IDLE, DONE});
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fail      <= 1'b0;
         fail_addr <= '0;
         fail_data <= '0;
      end else begin
         state_q   <= state_d;
         mem_we    <= we_d;
         mem_re    <= re_d;
         mem_addr  <= addr_d;
         mem_din   <= din_d;
         busy      <= busy_d;
         done      <= done_d;
         fail      <= fail_d;
         fail_addr <= fail_addr_d;
         fail_data <= fail_data_d;
      end
   end

   // one-cycle delayed read tag, lines up with mem_dout
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_vld_q  <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         rd_vld_q  <= mem_re;
         rd_addr_q <= mem_addr;
      end
   end

endmodule
